// File: rtl/line_buffer_3x3_if.sv
// Pixel stream in, 3x3 window stream out.
interface line_buffer_3x3_if #(
    parameter int unsigned ELEMENT_WIDTH = 32
);
    logic                     t;
    logic [ELEMENT_WIDTH-1:0] in_data;
    logic                     tout;
    logic [ELEMENT_WIDTH-1:0] win_data [2:0][2:0];
    logic                     frame_done;

    modport master (
        output t,
        output in_data,
        input  tout,
        input  win_data,
        input  frame_done
    );

    modport slave (
        input  t,
        input  in_data,
        output tout,
        output win_data,
        output frame_done
    );
endinterface

// File: rtl/line_buffer_3x3.sv
// Streaming 3x3 window generator: two row line buffers plus a 3x3 shift
// window; raises tout for every neighbourhood that lies fully inside the image.
module line_buffer_3x3 #(
    parameter int unsigned ELEMENT_WIDTH = 32,
    parameter int unsigned IMG_WIDTH     = 16,
    parameter int unsigned IMG_HEIGHT    = 16
) (
    input  logic            clk,
    input  logic            rst,
    line_buffer_3x3_if.slave bus
);
    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0]         col;
    logic [ROW_W-1:0]         row;
    logic [ELEMENT_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [ELEMENT_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [ELEMENT_WIDTH-1:0] win [2:0][2:0];
    logic                     tout_q;
    logic                     frame_done_q;

    logic last_col_c;
    logic last_row_c;

    assign last_col_c = (col == COL_W'(IMG_WIDTH - 1));
    assign last_row_c = (row == ROW_W'(IMG_HEIGHT - 1));

    // Counters, window shift register and output strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col          <= '0;
            row          <= '0;
            tout_q       <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (bus.t) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb0[col];
            win[1][2] <= lb1[col];
            win[2][2] <= bus.in_data;

            tout_q       <= (row >= ROW_W'(2)) && (col >= COL_W'(2));
            frame_done_q <= last_row_c && last_col_c;

            if (last_col_c) begin
                col <= '0;
                row <= last_row_c ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end else begin
            tout_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end
    end

    // Line buffers: read-before-write at the current column, never cleared.
    always_ff @(posedge clk) begin
        if (rst && bus.t) begin
            lb0[col] <= lb1[col];
            lb1[col] <= bus.in_data;
        end
    end

    assign bus.tout       = tout_q;
    assign bus.frame_done = frame_done_q;
    assign bus.win_data   = win;
endmodule

// File: tb/tb_line_buffer_3x3.sv
// Scoreboard bench: DUT a is 4x4, DUT b is 5x3 (non-square).
module tb_line_buffer_3x3;
    typedef struct packed {
        logic [8:0][31:0] w;
        logic             fd;
    } exp_t;

    logic clk;
    logic rst;

    line_buffer_3x3_if #(.ELEMENT_WIDTH(32)) bus_a ();
    line_buffer_3x3_if #(.ELEMENT_WIDTH(32)) bus_b ();

    line_buffer_3x3 #(.ELEMENT_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    line_buffer_3x3 #(.ELEMENT_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t             q_a [$];
    exp_t             q_b [$];
    logic [8:0][31:0] cap_a [$];
    logic [8:0][31:0] cap_b [$];
    int               tout_cnt [2];
    int               fd_cnt [2];
    logic             prev_t [2];

    function automatic logic [8:0][31:0] mk(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6, input int a7, input int a8);
        logic [8:0][31:0] v;
        v[0] = 32'(a0); v[1] = 32'(a1); v[2] = 32'(a2);
        v[3] = 32'(a3); v[4] = 32'(a4); v[5] = 32'(a5);
        v[6] = 32'(a6); v[7] = 32'(a7); v[8] = 32'(a8);
        return v;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_win(input string name, input logic [8:0][31:0] act,
                             input logic [8:0][31:0] exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %p expected %p", name, act, exp);
        end
    endtask

    // Monitor for one DUT, called every falling edge.
    task automatic mon_one(input int sel);
        logic             tv, fv, pt;
        logic [8:0][31:0] act;
        exp_t             e;
        bit               empty;
        if (sel == 0) begin
            tv = bus_a.tout; fv = bus_a.frame_done;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) act[i*3+j] = bus_a.win_data[i][j];
            pt = prev_t[0]; prev_t[0] = bus_a.t;
            empty = (q_a.size() == 0);
        end else begin
            tv = bus_b.tout; fv = bus_b.frame_done;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) act[i*3+j] = bus_b.win_data[i][j];
            pt = prev_t[1]; prev_t[1] = bus_b.t;
            empty = (q_b.size() == 0);
        end
        if (fv) fd_cnt[sel]++;
        if (tv) begin
            tout_cnt[sel]++;
            checks++;
            if (!pt) begin
                errors++;
                $display("FAIL tout_after_idle dut%0d: tout=1 but t was 0 in previous cycle", sel);
            end
            checks++;
            if (empty) begin
                errors++;
                $display("FAIL unexpected_tout dut%0d: got window %p expected no window", sel, act);
            end else begin
                e = (sel == 0) ? q_a.pop_front() : q_b.pop_front();
                if (act != e.w || fv != e.fd) begin
                    errors++;
                    $display("FAIL window dut%0d: got %p fd=%0b expected %p fd=%0b",
                             sel, act, fv, e.w, e.fd);
                end
            end
            if (sel == 0) cap_a.push_back(act);
            else          cap_b.push_back(act);
        end else if (fv) begin
            checks++;
            errors++;
            $display("FAIL stray_frame_done dut%0d: got frame_done=1 expected 0 without tout", sel);
        end
    endtask

    task automatic check_zero(input string name, input int sel);
        logic ok;
        ok = 1'b1;
        if (sel == 0) begin
            if (bus_a.tout || bus_a.frame_done) ok = 1'b0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) if (bus_a.win_data[i][j] != 32'd0) ok = 1'b0;
        end else begin
            if (bus_b.tout || bus_b.frame_done) ok = 1'b0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) if (bus_b.win_data[i][j] != 32'd0) ok = 1'b0;
        end
        check_int(name, int'(ok), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one pixel for one clock; entered and left at posedge+1.
    task automatic drive(input int sel, input int d);
        if (sel == 0) begin bus_a.t = 1'b1; bus_a.in_data = 32'(d); end
        else          begin bus_b.t = 1'b1; bus_b.in_data = 32'(d); end
        @(posedge clk);
        #1;
        bus_a.t = 1'b0;
        bus_b.t = 1'b0;
    endtask

    task automatic send_frame(input int sel, input int w, input int h, input int base,
                              input bit gap, input int npix);
        int   n;
        exp_t e;
        n = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (n >= npix) return;
                if (gap) idle(int'($urandom_range(0, 3)));
                if (r >= 2 && c >= 2) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            e.w[i*3+j] = 32'(base + w*(r-2+i) + (c-2+j));
                    e.fd = (r == h-1) && (c == w-1);
                    if (sel == 0) q_a.push_back(e);
                    else          q_b.push_back(e);
                end
                drive(sel, base + w*r + c);
                n++;
            end
        end
    endtask

    task automatic clear_stats();
        cap_a.delete(); cap_b.delete();
        tout_cnt[0] = 0; tout_cnt[1] = 0;
        fd_cnt[0] = 0;   fd_cnt[1] = 0;
    endtask

    initial begin
        rst = 1'b0;
        bus_a.t = 1'b0; bus_a.in_data = '0;
        bus_b.t = 1'b0; bus_b.in_data = '0;
        prev_t[0] = 1'b0; prev_t[1] = 1'b0;
        clear_stats();

        fork
            forever begin
                @(negedge clk);
                mon_one(0);
                mon_one(1);
            end
        join_none

        idle(2);
        check_zero("reset_state_a", 0);
        check_zero("reset_state_b", 1);
        rst = 1'b1;
        idle(1);

        // Basic 4x4 frame, t continuous.
        clear_stats();
        send_frame(0, 4, 4, 0, 1'b0, 16);
        idle(3);
        check_int("basic_drained", q_a.size(), 0);
        check_int("basic_tout_count", tout_cnt[0], 4);
        check_int("basic_frame_done_count", fd_cnt[0], 1);
        if (cap_a.size() == 4) begin
            check_win("basic_first", cap_a[0], mk(0, 1, 2, 4, 5, 6, 8, 9, 10));
            check_win("row_boundary", cap_a[2], mk(4, 5, 6, 8, 9, 10, 12, 13, 14));
            check_win("basic_last", cap_a[3], mk(5, 6, 7, 9, 10, 11, 13, 14, 15));
        end

        // Same image with random gaps between pixels.
        clear_stats();
        send_frame(0, 4, 4, 0, 1'b1, 16);
        idle(3);
        check_int("gap_drained", q_a.size(), 0);
        check_int("gap_tout_count", tout_cnt[0], 4);
        if (cap_a.size() == 4)
            check_win("gap_first", cap_a[0], mk(0, 1, 2, 4, 5, 6, 8, 9, 10));

        // Back-to-back frames with no bubble.
        clear_stats();
        send_frame(0, 4, 4, 0, 1'b0, 16);
        send_frame(0, 4, 4, 100, 1'b0, 16);
        idle(3);
        check_int("b2b_drained", q_a.size(), 0);
        check_int("b2b_tout_count", tout_cnt[0], 8);
        check_int("b2b_frame_done_count", fd_cnt[0], 2);
        if (cap_a.size() == 8)
            check_win("b2b_second_first", cap_a[4], mk(100, 101, 102, 104, 105, 106, 108, 109, 110));

        // Reset after pixel 9 (t held high to show reset wins), then a fresh frame.
        clear_stats();
        send_frame(0, 4, 4, 0, 1'b0, 10);
        rst = 1'b0;
        bus_a.t = 1'b1;
        bus_a.in_data = 32'd999;
        @(posedge clk);
        #1;
        check_zero("mid_reset_outputs", 0);
        rst = 1'b1;
        bus_a.t = 1'b0;
        idle(1);
        send_frame(0, 4, 4, 0, 1'b0, 16);
        idle(3);
        check_int("rst_drained", q_a.size(), 0);
        check_int("rst_tout_count", tout_cnt[0], 4);
        if (cap_a.size() == 4) begin
            check_win("rst_first", cap_a[0], mk(0, 1, 2, 4, 5, 6, 8, 9, 10));
            check_win("rst_last", cap_a[3], mk(5, 6, 7, 9, 10, 11, 13, 14, 15));
        end

        // Non-square 5x3, two frames to exercise counter wrap.
        clear_stats();
        send_frame(1, 5, 3, 0, 1'b0, 15);
        send_frame(1, 5, 3, 50, 1'b0, 15);
        idle(3);
        check_int("ns_drained", q_b.size(), 0);
        check_int("ns_tout_count", tout_cnt[1], 6);
        check_int("ns_frame_done_count", fd_cnt[1], 2);
        check_int("ns_dut_a_quiet", tout_cnt[0], 0);
        if (cap_b.size() == 6) begin
            check_win("ns_last", cap_b[2], mk(2, 3, 4, 7, 8, 9, 12, 13, 14));
            check_win("ns_wrap_first", cap_b[3], mk(50, 51, 52, 55, 56, 57, 60, 61, 62));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
